// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and load/store sides.
// Tracks the owner of each accepted transaction in an in-order tag FIFO to steer responses.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexp_rsp
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_tags [0:MAX_OUTSTANDING-1];
  logic          r_lock_v;
  logic          r_lock_owner;
  logic [SW-1:0] r_starve;
  logic          r_err;

  logic [CW-1:0] w_count;
  logic          w_lock_v;
  logic          w_full;
  logic          w_gnt_i;
  logic          w_gnt_d;
  logic          w_accept;
  logic          w_pop;
  logic          w_head;
  logic          w_owner_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // While reset is asserted the port behaves as if empty and unlocked.
  assign w_count  = resetn ? r_count : '0;
  assign w_lock_v = resetn & r_lock_v;
  assign w_full   = (w_count == COUNT_FULL);

  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    if (!w_full) begin
      if (w_lock_v) begin
        w_gnt_d = r_lock_owner;
        w_gnt_i = !r_lock_owner;
      end else if ((r_starve == STARVE_MAX) && inst_req) begin
        w_gnt_i = 1'b1;
      end else if (data_req) begin
        w_gnt_d = 1'b1;
      end else if (inst_req) begin
        w_gnt_i = 1'b1;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (w_gnt_d) begin
      mem_req   = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (w_gnt_i) begin
      mem_req   = inst_req;
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  assign w_accept    = mem_req && mem_addr_ok;
  assign w_pop       = mem_data_ok && (w_count != '0);
  assign w_head      = r_tags[r_rd_ptr];
  assign w_owner_req = r_lock_owner ? data_req : inst_req;

  assign inst_addr_ok  = w_gnt_i && inst_req && mem_addr_ok;
  assign data_addr_ok  = w_gnt_d && data_req && mem_addr_ok;
  assign inst_data_ok  = w_pop && !w_head;
  assign data_data_ok  = w_pop && w_head;
  assign inst_rdata    = mem_rdata;
  assign data_rdata    = mem_rdata;
  assign err_unexp_rsp = resetn & r_err;

  // Tag storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tags[r_wr_ptr] <= w_gnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_lock_v     <= 1'b0;
      r_lock_owner <= 1'b0;
      r_starve     <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      // Hold the grant on a stalled request so the port address stays stable.
      if (w_accept) begin
        r_lock_v <= 1'b0;
      end else if (mem_req) begin
        r_lock_v     <= 1'b1;
        r_lock_owner <= w_gnt_d;
      end else if (r_lock_v && !w_owner_req) begin
        r_lock_v <= 1'b0;
      end

      if (!inst_req || (w_accept && w_gnt_i)) begin
        r_starve <= '0;
      end else if (w_accept && w_gnt_d && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end

      if (mem_data_ok && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int MO = 2;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_unexp_rsp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_unexp_rsp(err_unexp_rsp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ordered list of owners (0 = inst, 1 = data) plus arbitration state.
  bit m_q[$];
  bit m_lock_v, m_lock_own, m_err;
  int m_starve;

  bit          o_acc_i, o_acc_d, o_dok_i, o_dok_d, o_mem_req;
  logic [31:0] o_mem_addr;
  bit          acc_seq [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock_v = 0; m_lock_own = 0; m_err = 0; m_starve = 0;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit live, full, gi, gd, e_req, e_wr, acc, pop;
    logic [1:0] e_size;
    logic [31:0] e_addr, e_wdata;
    int cnt;
    #4;
    live = resetn;
    cnt  = live ? m_q.size() : 0;
    full = (cnt == MO);
    gi = 0; gd = 0;
    if (!full) begin
      if (live && m_lock_v) begin gd = m_lock_own; gi = !m_lock_own; end
      else if (m_starve == SL && inst_req) gi = 1;
      else if (data_req) gd = 1;
      else if (inst_req) gi = 1;
    end
    e_req = 0; e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
    if (gd) begin
      e_req = data_req; e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
    end else if (gi) begin
      e_req = inst_req; e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wdata = inst_wdata;
    end
    chk("mem_req", mem_req, e_req);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_size", mem_size, e_size);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("inst_addr_ok", inst_addr_ok, gi && inst_req && mem_addr_ok);
    chk("data_addr_ok", data_addr_ok, gd && data_req && mem_addr_ok);
    chk("inst_data_ok", inst_data_ok, mem_data_ok && cnt != 0 && m_q[0] == 1'b0);
    chk("data_data_ok", data_data_ok, mem_data_ok && cnt != 0 && m_q[0] == 1'b1);
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("err_unexp_rsp", err_unexp_rsp, live ? m_err : 1'b0);
    o_acc_i = inst_addr_ok; o_acc_d = data_addr_ok;
    o_dok_i = inst_data_ok; o_dok_d = data_data_ok;
    o_mem_req = mem_req; o_mem_addr = mem_addr;
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      acc = e_req && mem_addr_ok;
      pop = mem_data_ok && cnt != 0;
      if (mem_data_ok && cnt == 0) begin
        m_err = 1;
        $display("t=%0t stray response", $time);
      end
      if (pop) begin
        $display("t=%0t response to %s rdata=%h", $time, m_q[0] ? "data" : "inst", mem_rdata);
        void'(m_q.pop_front());
      end
      if (acc) begin
        m_q.push_back(gd);
        $display("t=%0t accept %s addr=%h wr=%0d", $time, gd ? "data" : "inst", e_addr, e_wr);
      end
      if (acc) m_lock_v = 0;
      else if (e_req && !mem_addr_ok) begin m_lock_v = 1; m_lock_own = gd; end
      else if (m_lock_v && !(m_lock_own ? data_req : inst_req)) m_lock_v = 0;
      if (!inst_req || (acc && gi)) m_starve = 0;
      else if (acc && gd && m_starve < SL) m_starve++;
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < MO + 1; k++) begin
      idle();
      mem_data_ok = (m_q.size() != 0);
      step();
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    step();
    step();
    resetn = 1;
  endtask

  initial begin
    idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Single load
    data_req = 1; data_addr = 32'h1000; mem_addr_ok = 1;
    step();
    chk("load_addr_ok", o_acc_d, 1);
    idle(); step();
    mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("load_data_ok", o_dok_d, 1);
    chk("load_inst_data_ok", o_dok_i, 0);

    // Priority and ordering
    idle(); inst_req = 1; inst_addr = 32'h400; data_req = 1; data_addr = 32'h2000; mem_addr_ok = 1;
    step();
    chk("prio_first_data", o_acc_d, 1);
    chk("prio_first_not_inst", o_acc_i, 0);
    data_req = 0;
    step();
    chk("prio_second_inst", o_acc_i, 1);
    idle(); step();
    mem_data_ok = 1; mem_rdata = 32'h11112222;
    step();
    chk("order_first_data", o_dok_d, 1);
    mem_rdata = 32'h33334444;
    step();
    chk("order_second_inst", o_dok_i, 1);
    idle(); step();

    // Starvation: D D D I repeating with prompt responses
    for (int k = 0; k < 8; k++) begin
      inst_req = 1; inst_addr = 32'h500 + 4 * k; data_req = 1; data_addr = 32'h3000 + 4 * k;
      mem_addr_ok = 1; mem_data_ok = (m_q.size() != 0); mem_rdata = $urandom;
      step();
      acc_seq[k] = o_acc_d;
    end
    for (int k = 0; k < 8; k++) chk($sformatf("starve_grant%0d", k), acc_seq[k], (k % 4) != 3);
    drain();

    // Lock on a stalled inst request
    inst_req = 1; inst_addr = 32'h0000_0600;
    step();
    data_req = 1; data_addr = 32'h0000_4000;
    step();
    chk("lock_addr1", o_mem_addr, 32'h0000_0600);
    step();
    chk("lock_addr2", o_mem_addr, 32'h0000_0600);
    mem_addr_ok = 1;
    step();
    chk("lock_accept_inst", o_acc_i, 1);
    step();
    chk("lock_then_data", o_acc_d, 1);
    drain();

    // Full and wrap
    do_reset();
    for (int k = 0; k < 7; k++) begin
      idle(); data_req = 1; data_addr = 32'h5000 + 4 * k; mem_addr_ok = 1;
      mem_data_ok = (k == 5);
      step();
      if (k >= 2 && k <= 5) chk($sformatf("full_no_req%0d", k), o_mem_req, 0);
      if (k == 6) chk("full_reaccept", o_acc_d, 1);
    end
    drain();

    // Stray response and reset
    mem_data_ok = 1;
    step();
    chk("stray_no_dok", o_dok_i | o_dok_d, 0);
    idle(); step();
    chk("stray_err_set", err_unexp_rsp, 1);
    data_req = 1; mem_addr_ok = 1;
    step(); step();
    idle(); resetn = 0;
    step();
    chk("reset_clears_err", err_unexp_rsp, 0);
    resetn = 1; mem_data_ok = 1;
    step();
    chk("post_reset_stray", o_dok_i | o_dok_d, 0);
    idle(); step();
    chk("post_reset_err", err_unexp_rsp, 1);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 500; k++) begin
      inst_req   = ($urandom_range(0, 9) < 7);
      inst_wr    = $urandom_range(0, 1);
      inst_size  = 2'($urandom_range(0, 3));
      inst_addr  = $urandom;
      inst_wdata = $urandom;
      data_req   = ($urandom_range(0, 9) < 7);
      data_wr    = $urandom_range(0, 1);
      data_size  = 2'($urandom_range(0, 3));
      data_addr  = $urandom;
      data_wdata = $urandom;
      mem_addr_ok = ($urandom_range(0, 9) < 6);
      mem_data_ok = (m_q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      mem_rdata  = $urandom;
      resetn     = ($urandom_range(0, 99) != 0);
      step();
    end
    resetn = 1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single SRAM-like data-memory port between the instruction-fetch requester (IF stage) and the load/store requester (EXE/MEM stages). Each cycle it picks one requester, drives the shared port, and records the owner of every accepted transaction in an in-order tag FIFO. Each returning `data_ok` is steered back to the correct requester. It sits between the pipeline core and the AXI bridge.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions (tag FIFO depth, ≥1).
- `STARVE_LIMIT`, default 3: consecutive data-side wins, while inst is waiting, before inst is forced to win.
- `clk` in 1: clock. Everything is rising-edge.
- `resetn` in 1: reset, synchronous, active-low.
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_addr[31:0]`, `inst_wdata[31:0]` in: IF-side request.
- `inst_addr_ok` out 1: IF request accepted this cycle.
- `inst_data_ok` out 1: response for IF this cycle.
- `inst_rdata` out 32: read data, equal to `mem_rdata`.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wdata[31:0]` in: load/store-side request.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: same meanings, for the data side.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]` out: shared port request.
- `mem_addr_ok` in 1, `mem_data_ok` in 1, `mem_rdata` in 32: shared port handshake and response.
- `err_unexp_rsp` out 1: sticky flag. Set when `mem_data_ok` arrives while no transaction is outstanding.

## Operation
- **Handshake.** A transaction is accepted when `mem_req && mem_addr_ok`. It completes when `mem_data_ok` is high. Responses return in acceptance order.
- **Grant.** The grant is decided combinationally each cycle, in priority order:
  1. If `count == MAX_OUTSTANDING`: no grant, and `mem_req = 0`.
  2. Else if `lock_v`: grant `lock_owner`.
  3. Else if `starve_cnt == STARVE_LIMIT && inst_req`: grant inst.
  4. Else if `data_req`: grant data.
  5. Else if `inst_req`: grant inst.
  6. Else: no grant.
- **Port drive.** `mem_*` carries the granted requester's fields, and `mem_req` equals that requester's req. With no grant, `mem_*` are all 0.
- **addr_ok routing.** `mem_addr_ok` is passed only to the granted side, as `X_addr_ok = grant_X && X_req && mem_addr_ok`.
- **Lock.**
  - Set on `mem_req && !mem_addr_ok`: `lock_v <= 1`, `lock_owner <=` the granted side. This keeps the address stable until the request is accepted.
  - Cleared on acceptance, or when the locked owner drops its req.
- **Tag FIFO.** Depth `MAX_OUTSTANDING`, 1 bit per entry (0 = inst, 1 = data). Counter `count` is `$clog2(MAX_OUTSTANDING+1)` bits wide.
  - Push the owner on acceptance.
  - Pop the head on `mem_data_ok && count != 0`.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance, wrapping modulo `MAX_OUTSTANDING`.
- **Response steering.**
  - `inst_data_ok = mem_data_ok && count != 0 && head == 0`.
  - `data_data_ok = mem_data_ok && count != 0 && head == 1`.
  - `inst_rdata` and `data_rdata` both equal `mem_rdata` unconditionally.
  - Write responses are steered the same way as read responses.
- **Stray response.** `mem_data_ok` with `count == 0` is dropped: no `X_data_ok`, no pointer change. It sets `err_unexp_rsp`, which stays set until reset.
- **Starvation counter.** `starve_cnt` is a saturating counter, sized to hold `STARVE_LIMIT`.
  - +1 on a data acceptance while `inst_req` is high.
  - Cleared to 0 on an inst acceptance, or in any cycle with `inst_req == 0`.

## Timing
- **Reset** (`resetn == 0` at a clock edge): `count`, both pointers, `lock_v`, `starve_cnt` and `err_unexp_rsp` are cleared. All outstanding transactions are forgotten; responses arriving afterwards count as stray.
- **Outputs during reset:** `err_unexp_rsp = 0`. All other outputs follow the combinational rules with `count = 0` and `lock_v = 0`.
- **Latency:** zero cycles through the arbiter on both paths. `mem_addr_ok → X_addr_ok` and `mem_data_ok → X_data_ok` are combinational, with no added bubble.
- **Back-to-back:** one acceptance per cycle is sustained while `count < MAX_OUTSTANDING`.
- **Full case:** with `count == MAX_OUTSTANDING`, a pop in cycle N allows `mem_req` again in cycle N+1. It is never allowed in the same cycle as the pop, so there is no combinational path from `data_ok` to `req`.
- **Simultaneous requests,** no lock, `starve_cnt < STARVE_LIMIT`: data wins and inst sees `inst_addr_ok = 0`.

## Test plan
- **Single load:** `data_req=1`, `data_addr=0x1000`; `mem_addr_ok=1` in cycle 0; `mem_data_ok=1`, `mem_rdata=0xDEADBEEF` in cycle 2 → `data_addr_ok=1` in cycle 0, `data_data_ok=1` with `data_rdata=0xDEADBEEF` in cycle 2, `inst_data_ok=0` throughout.
- **Priority and ordering:** `inst_req` and `data_req` both high; `mem_addr_ok=1` for 2 cycles → data is accepted in cycle 0 and inst in cycle 1. Two responses in cycles 3 and 4 → `data_data_ok` in cycle 3, `inst_data_ok` in cycle 4.
- **Starvation:** `STARVE_LIMIT=3`, both requesting, `mem_addr_ok=1`, responses returned promptly → the grant sequence is D, D, D, I, D, D, D, I…
- **Lock:** inst is granted with `mem_addr_ok=0` for 3 cycles; `data_req` rises in cycle 1 → `mem_addr` stays at `inst_addr` until acceptance in cycle 3. Data is granted in cycle 4.
- **Full and wrap:** `MAX_OUTSTANDING=2`, 3 data requests, `mem_addr_ok=1`, no response → `mem_req=0` from cycle 2. `mem_data_ok` in cycle 5 → third request accepted in cycle 6. Continue 8 transactions and check order across pointer wrap.
- **Stray and reset:** `mem_data_ok=1` with nothing outstanding → no `X_data_ok`, `err_unexp_rsp=1` from the next cycle. A reset pulse with 2 outstanding clears `err_unexp_rsp` and `count`; a later `mem_data_ok` sets `err_unexp_rsp` again.
